rlbp_serial_rx: RTL and testbench
=================================

// Module: rlbp_serial_rx
// PURPOSE
//  Serial-to-parallel receiver for the RLBP P2S serial output stream. Samples s_data_i on s_valid_i,
//  assembles bytes, buffers them in a small FIFO and presents them to the Caravel core through a
//  Wishbone slave. Sits in the user project area next to the RLBP macro and closes the serial link
//  back to software.
// PARAMETERS
//  DEPTH      8            FIFO depth in bytes; power of two, 2..16
//  BASE_NIB   4'h3         wbs_adr_i[31:28] value that selects this block
//  OFF_BASE   8'h10        wbs_adr_i[7:4] window; word offsets 0x0 DATA, 0x4 STATUS, 0x8 CTRL
// PORTS
//  wb_clk_i    in   1   single clock, all logic posedge
//  wb_rst_i    in   1   synchronous, active-high reset
//  wbs_stb_i   in   1   Wishbone strobe
//  wbs_cyc_i   in   1   Wishbone cycle
//  wbs_we_i    in   1   Wishbone write enable
//  wbs_sel_i   in   4   byte selects; only sel[0] is honoured on writes
//  wbs_dat_i   in   32  write data
//  wbs_adr_i   in   32  address
//  wbs_ack_o   out  1   one-cycle acknowledge
//  wbs_dat_o   out  32  read data, valid while ack is high
//  s_data_i    in   1   serial data bit, MSB first by default
//  s_valid_i   in   1   bit strobe; s_data_i sampled on each cycle it is high
//  s_sync_i    in   1   frame sync; forces bit counter to 0, partial byte discarded
//  irq_o       out  1   level interrupt: CTRL.irq_en & ~empty
// BEHAVIOUR
//  Reset: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, FIFO empty, bit counter 0, CTRL=0, overflow=0.
//  CTRL[0] enable, CTRL[1] lsb_first, CTRL[2] irq_en, CTRL[3] clear (self-clearing; flushes FIFO,
//   bit counter and sticky flags in the cycle after the write).
//  Receive: when enable & s_valid_i, shift in the bit and increment bit counter 0..7. On the 8th bit
//   the full byte (shift reg + current bit) is pushed in the same edge. It is readable from the next
//   cycle. Counter wraps to 0.
//  s_sync_i has priority over s_valid_i in the same cycle: counter=0, the bit is not sampled.
//  enable=0: s_valid_i is ignored and the counter is held at 0. Deasserting enable mid-byte drops the
//   partial byte.
//  Push when full: byte dropped, STATUS.overflow sticky set. Push and pop in the same cycle while full:
//   both happen, no overflow.
//  Wishbone: hit = cyc & stb & adr[31:28]==BASE_NIB & adr[7:4]==OFF_BASE[3:0] & ~ack. On the edge
//   after a hit, ack=1 for exactly one cycle with registered wbs_dat_o. A non-hit access is never acked.
//  DATA read: returns {24'b0, head byte} and pops. Read while empty returns 0 with no state change.
//   DATA writes are ignored.
//  STATUS read: [4:0] count, [8] empty, [9] full, [10] overflow, [11] parity_err.
//   Writing 1 to bit 10 or bit 11 clears that flag.
//  CTRL read/write: [3:0]; a write with sel[0]=0 is acked but has no effect.
//  A hit to any other offset in the window: acked, reads 0, writes ignored.
//  Pointers are log2(DEPTH)+1 bits wide. Empty/full come from MSB compare.
//  Reset mid-frame or mid-transaction aborts everything; no ack after reset.
// CONFIGURATION
//  RLBP_RX_PARITY_EN defined: each frame is 9 bits; 9th bit is even parity over the 8 data bits.
//   A mismatch sets STATUS.parity_err sticky and the byte is still pushed. Counter runs 0..8.
//  RLBP_RX_PARITY_EN undefined: 8-bit frames and parity_err reads 0.
// STRUCTURE
//  Package rlbp_rx_pkg: register offsets, CTRL/STATUS bit indices, BASE_NIB default, frame length.
//  One sub-module: rlbp_rx_fifo (sync FIFO, DEPTH x 8, push/pop/count/full/empty).
//  Top holds the shifter, bit counter, register file and WB slave.
// TESTING
//  1 CTRL=0x1, send 0xA5 MSB first via 8 s_valid_i pulses -> DATA read 0x000000A5, then STATUS.empty=1.
//  2 CTRL=0x3 (lsb_first), send bits 1,0,0,0,0,0,0,0 -> DATA reads 0x01.
//  3 Send 9 bytes with DEPTH=8 and no reads -> count=8, full=1, overflow=1, first 8 bytes read back
//    in order. Write STATUS=0x400 -> overflow=0.
//  4 Send 4 bits, pulse s_sync_i, then send 0x3C -> only 0x3C in FIFO, count=1.
//  5 irq_en=1, push one byte -> irq_o=1 next cycle. Pop -> irq_o=0. Empty DATA read -> 0, count stays 0.
//  6 PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1, byte 0x07 stored. Reset mid-byte ->
//    all outputs 0, count 0.

Source files
------------

// File: rtl/rlbp_rx_pkg.sv
// Shared constants for the RLBP serial receiver: Wishbone register offsets,
// CTRL/STATUS bit positions, default address decode and frame length.
// Frame length depends on RLBP_RX_PARITY_EN (9-bit frames with even parity when defined).
package rlbp_rx_pkg;

  localparam logic [3:0] BASE_NIB_DEF = 4'h3;
  localparam logic [7:0] OFF_BASE_DEF = 8'h10;

  // Word offsets inside the register window (wbs_adr_i[3:0])
  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  // CTRL bits
  localparam int CTRL_EN  = 0;
  localparam int CTRL_LSB = 1;
  localparam int CTRL_IRQ = 2;
  localparam int CTRL_CLR = 3;

  // STATUS bits
  localparam int ST_OVF  = 10;
  localparam int ST_PERR = 11;

`ifdef RLBP_RX_PARITY_EN
  localparam logic [3:0] FRAME_LEN = 4'd9;
`else
  localparam logic [3:0] FRAME_LEN = 4'd8;
`endif

endpackage

// File: rtl/rlbp_rx_fifo.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished by comparing the MSBs. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module rlbp_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush returns to empty
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write, no reset needed since empty masks stale entries
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rlbp_serial_rx.sv
// RLBP serial receiver: bit shifter and counter, byte FIFO, CTRL/STATUS
// registers and a single-cycle-ack Wishbone slave.
// Optional feature macro: RLBP_RX_PARITY_EN (9th frame bit is even parity).
// Wishbone handshake: a hit (cyc & stb & address match & ~ack) is acked on
// the following edge for exactly one cycle; read data is valid while ack is high.
module rlbp_serial_rx
  import rlbp_rx_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter logic [3:0] BASE_NIB = BASE_NIB_DEF,
  parameter logic [7:0] OFF_BASE = OFF_BASE_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        s_data_i,
  input  logic        s_valid_i,
  input  logic        s_sync_i,
  output logic        irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    ctrl;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic [3:0]    bit_cnt;
  logic          overflow;
  logic          parity_err;
  logic          flush;
  logic          sample;
  logic          last_bit;
  logic          push;
  logic [7:0]    push_data;
  logic          par_bad;
  logic          pop;
  logic          ovf_set;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic [4:0]    count5;
  logic          full;
  logic          empty;
  logic          hit;
  logic [3:0]    off;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign flush  = ctrl[CTRL_CLR];
  assign sample = ctrl[CTRL_EN] & s_valid_i & ~s_sync_i & ~flush;
  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB)
                & (wbs_adr_i[7:4] == OFF_BASE[3:0]) & ~wbs_ack_o;
  assign off    = wbs_adr_i[3:0];
  assign pop    = hit & ~wbs_we_i & (off == OFF_DATA) & ~flush;
  assign ovf_set = push & full & ~pop;
  assign count5 = 5'(count);
  assign irq_o  = ctrl[CTRL_IRQ] & ~empty;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[27:8], wbs_dat_i[31:12], wbs_dat_i[9:4]};

  // Next shift value, frame-end detection and parity check
  always_comb begin
    shift_next = ctrl[CTRL_LSB] ? {s_data_i, shift_reg[7:1]} : {shift_reg[6:0], s_data_i};
    last_bit   = (bit_cnt == FRAME_LEN - 4'd1);
    push       = sample & last_bit;
`ifdef RLBP_RX_PARITY_EN
    push_data  = shift_reg;
    par_bad    = push & ((^shift_reg) != s_data_i);
`else
    push_data  = shift_next;
    par_bad    = 1'b0;
`endif
  end

  // Bit counter and shift register; sync, disable and flush drop the partial frame
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (flush || s_sync_i || !ctrl[CTRL_EN]) bit_cnt <= '0;
      else if (s_valid_i) bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
`ifdef RLBP_RX_PARITY_EN
      if (sample && !last_bit) shift_reg <= shift_next;
`else
      if (sample) shift_reg <= shift_next;
`endif
    end
  end

  // Read mux for the addressed register
  always_comb begin
    rdata = '0;
    case (off)
      OFF_DATA:   rdata = empty ? 32'd0 : {24'd0, head};
      OFF_STATUS: rdata = {20'd0, parity_err, overflow, full, empty, 3'd0, count5};
      OFF_CTRL:   rdata = {28'd0, ctrl};
      default:    rdata = '0;
    endcase
  end

  // Register file, sticky flags and Wishbone acknowledge
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl       <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= '0;
      if (flush) begin
        ctrl[CTRL_CLR] <= 1'b0;
        overflow       <= 1'b0;
        parity_err     <= 1'b0;
      end else begin
        if (hit && wbs_we_i && off == OFF_STATUS) begin
          if (wbs_dat_i[ST_OVF])  overflow   <= 1'b0;
          if (wbs_dat_i[ST_PERR]) parity_err <= 1'b0;
        end
        if (ovf_set) overflow   <= 1'b1;
        if (par_bad) parity_err <= 1'b1;
      end
      if (hit && wbs_we_i && off == OFF_CTRL && wbs_sel_i[0]) ctrl <= wbs_dat_i[3:0];
      if (hit && !wbs_we_i) wbs_dat_o <= rdata;
    end
  end

  rlbp_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (flush),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_rlbp_serial_rx.sv
// Testbench for rlbp_serial_rx: directed steps plus a randomized phase,
// checked against a byte-queue reference model of the receiver.
// Honours RLBP_RX_PARITY_EN for frame length and the parity step.
module tb_rlbp_serial_rx;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_DATA   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_CTRL   = 32'h3000_0008;
  localparam logic [31:0] A_RSVD   = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        s_data, s_valid, s_sync;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_perr;
  logic [3:0] m_ctrl;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rlbp_serial_rx #(.DEPTH(DEPTH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .s_data_i  (s_data),
    .s_valid_i (s_valid),
    .s_sync_i  (s_sync),
    .irq_o     (irq)
  );

  // ---------------- model ----------------
  function automatic logic [31:0] exp_status();
    logic [4:0] n;
    n = 5'(exp_q.size());
    return {20'd0, m_perr, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0, 3'd0, n};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    m_ctrl = 4'd0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (m_ctrl[0]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovf = 1'b1;
    end
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_i = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) break;
    end
    r = dat_o;
    check("wb_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = '0; sel = '0;
    @(posedge clk); #1;
    check("wb_ack_one_cycle", {31'd0, ack}, 32'd0);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(a, 1'b1, d, s, r);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(a, 1'b0, 32'd0, 4'd0, r);
    check(tag, r, exp);
  endtask

  task automatic write_ctrl(input logic [3:0] v);
    wb_wr(A_CTRL, {28'd0, v}, 4'hF);
    if (v[3]) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end
    m_ctrl = v & 4'h7;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] exp;
    exp = (exp_q.size() == 0) ? 32'd0 : {24'd0, exp_q.pop_front()};
    rd_check(tag, A_DATA, exp);
  endtask

  task automatic send_bit(input logic b);
    s_valid = 1'b1; s_data = b;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_data_bits(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(m_ctrl[1] ? b[i] : b[7-i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_data_bits(b);
`ifdef RLBP_RX_PARITY_EN
    send_bit(^b);
`endif
    model_push(b);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] rb;
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
    s_data = 0; s_valid = 0; s_sync = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_check("rst_status", A_STATUS, exp_status());
    rd_check("rst_ctrl", A_CTRL, 32'd0);

    // MSB-first byte
    write_ctrl(4'h1);
    send_byte(8'hA5);
    read_data("msb_a5");
    rd_check("msb_status_empty", A_STATUS, exp_status());

    // LSB-first: bits 1,0,0,0,0,0,0,0 -> 0x01
    write_ctrl(4'h3);
    send_byte(8'h01);
    read_data("lsb_01");

    // Overflow: nine bytes into an eight-deep FIFO
    write_ctrl(4'h1);
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)));
    rd_check("ovf_status", A_STATUS, exp_status());
    for (int i = 0; i < DEPTH; i++) read_data("ovf_readback");
    wb_wr(A_STATUS, 32'h400, 4'hF);
    m_ovf = 1'b0;
    rd_check("ovf_cleared", A_STATUS, exp_status());

    // Partial byte then sync (with a coincident strobe that must be ignored)
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    s_sync = 1'b1; s_valid = 1'b1; s_data = 1'b1;
    @(posedge clk); #1;
    s_sync = 1'b0; s_valid = 1'b0; s_data = 1'b0;
    send_byte(8'h3C);
    rd_check("sync_status", A_STATUS, exp_status());
    read_data("sync_3c");

    // Interrupt
    write_ctrl(4'h5);
    check("irq_idle", {31'd0, irq}, 32'd0);
    send_byte(8'($urandom_range(0, 255)));
    check("irq_set", {31'd0, irq}, 32'd1);
    read_data("irq_pop");
    check("irq_clear", {31'd0, irq}, 32'd0);
    read_data("empty_read");
    rd_check("empty_status", A_STATUS, exp_status());

    // Disabled receiver ignores strobes; disable mid-byte drops the partial byte
    write_ctrl(4'h0);
    send_data_bits(8'hFF);
    rd_check("disabled_status", A_STATUS, exp_status());
    write_ctrl(4'h1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    write_ctrl(4'h0);
    write_ctrl(4'h1);
    send_byte(8'h5A);
    rd_check("middis_status", A_STATUS, exp_status());
    read_data("middis_5a");

    // CTRL write with sel[0]=0 has no effect; reserved offset reads 0; DATA writes ignored
    wb_wr(A_CTRL, 32'h6, 4'hE);
    rd_check("ctrl_sel0", A_CTRL, {28'd0, m_ctrl});
    wb_wr(A_DATA, 32'hAB, 4'hF);
    rd_check("data_write_ignored", A_STATUS, exp_status());
    rd_check("rsvd_read", A_RSVD, 32'd0);

    // Non-hit accesses are never acked
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4000_0004;
    repeat (3) begin @(posedge clk); #1; check("nohit_nib", {31'd0, ack}, 32'd0); end
    adr = 32'h3000_0014;
    repeat (3) begin @(posedge clk); #1; check("nohit_win", {31'd0, ack}, 32'd0); end
    cyc = 1'b0; stb = 1'b0;

    // Clear flushes FIFO and sticky flags and self-clears
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom_range(0, 255)));
    write_ctrl(4'h9);
    rd_check("clear_status", A_STATUS, exp_status());
    rd_check("clear_ctrl", A_CTRL, 32'h1);

`ifdef RLBP_RX_PARITY_EN
    // 0x07 has odd weight, so a 0 parity bit is an error; byte still stored
    send_data_bits(8'h07);
    send_bit(1'b0);
    model_push(8'h07);
    m_perr = 1'b1;
    rd_check("parity_status", A_STATUS, exp_status());
    read_data("parity_07");
    wb_wr(A_STATUS, 32'h800, 4'hF);
    m_perr = 1'b0;
    rd_check("parity_cleared", A_STATUS, exp_status());
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: write_ctrl({1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1});
        1, 2: begin
          rb = 8'($urandom_range(0, 255));
          send_byte(rb);
        end
        3: read_data("rand_data");
        default: begin
          rd_check("rand_status", A_STATUS, exp_status());
          check("rand_irq", {31'd0, irq}, {31'd0, m_ctrl[2] & (exp_q.size() != 0)});
        end
      endcase
    end
    while (exp_q.size() != 0) read_data("drain");
    rd_check("drain_status", A_STATUS, exp_status());

    // Reset mid-byte and mid-transaction
    write_ctrl(4'h5);
    send_byte(8'h81);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_dat", dat_o, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("midrst_ack_after", {31'd0, ack}, 32'd0);
    rd_check("midrst_status", A_STATUS, exp_status());
    rd_check("midrst_ctrl", A_CTRL, 32'd0);
    write_ctrl(4'h1);
    send_byte(8'hC3);
    rd_check("postrst_status", A_STATUS, exp_status());
    read_data("postrst_c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #500000;
    $display("FAIL global_timeout: observed no completion, required completion before 500000");
    $fatal(1, "timeout");
  end

endmodule
